spi_xfer_ctrl: RTL and testbench

Transfer sequencer for the APB SPI lite master, sitting directly upstream of the TX shift register. It accepts a word from the register block, then drives the shifter's `ld`, `sh_en` and `sh_rl` controls one bit at a time. It registers the shifter's `sdo` onto MOSI, generates SCLK and CS_n, and deserialises MISO into `rx_data_o`. SPI mode is CPHA=0 only, with CPOL selectable.

---
 rtl/spi_xfer_ctrl.sv | 144 ++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_ctrl.sv
// SPI (CPHA=0) transfer sequencer: loads the TX shifter, steps it one bit per SCLK
// period, drives SCLK/CS_n/MOSI and deserialises MISO into rx_data_o.
module spi_xfer_ctrl #(
  parameter int DATAWIDTH = 8,
  parameter int CLKDIV_W  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [DATAWIDTH-1:0] tx_data_i,
  input  logic                 lsb_first_i,
  input  logic                 cpol_i,
  input  logic [CLKDIV_W-1:0]  clk_div_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [DATAWIDTH-1:0] rx_data_o,
  output logic                 sh_ld_o,
  output logic [DATAWIDTH-1:0] sh_data_o,
  output logic                 sh_en_o,
  output logic                 sh_rl_o,
  input  logic                 sdo_i,
  output logic                 sclk_o,
  output logic                 cs_n_o,
  output logic                 mosi_o,
  input  logic                 miso_i,
  output logic [2:0]           state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT_L = 3'd3,
    S_WAIT_H = 3'd4,
    S_HOLD   = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  // One extra bit so clk_div_i = all-ones yields D = 2^CLKDIV_W without wrapping.
  localparam int DIV_W = CLKDIV_W + 1;
  localparam int CNT_W = $clog2(DATAWIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATAWIDTH - 1);

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     d_q;
  logic [DIV_W-1:0]     div_cnt_q;
  logic [CNT_W-1:0]     bit_cnt_q;
  logic                 cpol_q;
  logic [DATAWIDTH-1:0] rx_q;
  logic                 phase_end;
  logic                 accept;
  logic                 in_wait;
  logic                 busy_d, sh_ld_d, sh_en_d, done_d;

  assign phase_end = (div_cnt_q == d_q);
  assign accept    = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign in_wait   = (state_q == S_WAIT_L) || (state_q == S_WAIT_H) || (state_q == S_HOLD);
  assign state_o   = state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy_d  = 1'b0;
    sh_ld_d = 1'b0;
    sh_en_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE:   if (start_i) state_d = S_LOAD;
      S_LOAD:   state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT_L;
      S_WAIT_L: if (phase_end) state_d = S_WAIT_H;
      S_WAIT_H: if (phase_end) state_d = (bit_cnt_q == LAST_BIT) ? S_HOLD : S_LAUNCH;
      S_HOLD:   if (phase_end) state_d = S_DONE;
      S_DONE:   state_d = start_i ? S_LOAD : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // Outputs are registered from the next state so they line up with it.
    busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
    sh_ld_d = (state_d == S_LOAD);
    sh_en_d = (state_d == S_LAUNCH);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      rx_data_o <= '0;
      sh_ld_o   <= 1'b0;
      sh_data_o <= '0;
      sh_en_o   <= 1'b0;
      sh_rl_o   <= 1'b0;
      sclk_o    <= 1'b0;
      cs_n_o    <= 1'b1;
      mosi_o    <= 1'b0;
      d_q       <= '0;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      cpol_q    <= 1'b0;
      rx_q      <= '0;
    end else begin
      busy_o  <= busy_d;
      cs_n_o  <= ~busy_d;
      sh_ld_o <= sh_ld_d;
      sh_en_o <= sh_en_d;
      done_o  <= done_d;

      if (accept) begin
        d_q       <= DIV_W'(clk_div_i) + DIV_W'(1);
        cpol_q    <= cpol_i;
        sh_data_o <= tx_data_i;
        sh_rl_o   <= lsb_first_i;
      end

      if (state_d != state_q) div_cnt_q <= DIV_W'(1);
      else if (in_wait)       div_cnt_q <= div_cnt_q + DIV_W'(1);

      if (state_q == S_LOAD)
        bit_cnt_q <= '0;
      else if ((state_q == S_WAIT_H) && phase_end)
        bit_cnt_q <= bit_cnt_q + CNT_W'(1);

      if (state_q == S_LAUNCH) mosi_o <= sdo_i;

      // Leading edge and MISO sample share the last WAIT_L edge (CPHA=0).
      if ((state_q == S_WAIT_L) && phase_end) begin
        sclk_o <= ~cpol_q;
        if (sh_rl_o) rx_q <= {miso_i, rx_q[DATAWIDTH-1:1]};
        else         rx_q <= {rx_q[DATAWIDTH-2:0], miso_i};
      end else if ((state_q == S_WAIT_H) && phase_end) begin
        sclk_o <= cpol_q;
      end else if ((state_d == S_IDLE) || accept) begin
        sclk_o <= cpol_i;
      end

      if (state_d == S_DONE) rx_data_o <= rx_q;
    end
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: behavioural shifter stand-in, timing/bit-order reference
// computed from cycle arithmetic, MOSI bit queue and RX word expectations.
module tb_spi_xfer_ctrl;
  localparam int N  = 8;
  localparam int CW = 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [N-1:0]  tx_data_i;
  logic          lsb_first_i;
  logic          cpol_i;
  logic [CW-1:0] clk_div_i;
  logic          busy_o, done_o;
  logic [N-1:0]  rx_data_o;
  logic          sh_ld_o;
  logic [N-1:0]  sh_data_o;
  logic          sh_en_o, sh_rl_o;
  logic          sdo_i;
  logic          sclk_o, cs_n_o, mosi_o;
  logic          miso_i;
  logic [2:0]    state_o;

  int           n_cmp;
  int           n_err;
  logic [N-1:0] last_rx;
  logic         miso_loop;
  logic         miso_drv;
  logic [N-1:0] sh_reg = '0;

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  spi_xfer_ctrl #(.DATAWIDTH(N), .CLKDIV_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .tx_data_i(tx_data_i),
    .lsb_first_i(lsb_first_i), .cpol_i(cpol_i), .clk_div_i(clk_div_i),
    .busy_o(busy_o), .done_o(done_o), .rx_data_o(rx_data_o),
    .sh_ld_o(sh_ld_o), .sh_data_o(sh_data_o), .sh_en_o(sh_en_o), .sh_rl_o(sh_rl_o),
    .sdo_i(sdo_i), .sclk_o(sclk_o), .cs_n_o(cs_n_o), .mosi_o(mosi_o),
    .miso_i(miso_i), .state_o(state_o)
  );

  // Stand-in for the downstream TX shift register.
  always @(posedge clk_i) begin
    if (sh_ld_o)      sh_reg <= sh_data_o;
    else if (sh_en_o) sh_reg <= sh_rl_o ? {1'b0, sh_reg[N-1:1]} : {sh_reg[N-2:0], 1'b0};
  end
  assign sdo_i  = sh_rl_o ? sh_reg[0] : sh_reg[N-1];
  assign miso_i = miso_loop ? mosi_o : miso_drv;

  // ---------------- driver tasks ----------------
  task automatic begin_xfer(input logic [N-1:0] tx, input logic lsb, input logic cpol,
                            input logic [CW-1:0] div);
    @(negedge clk_i);
    start_i = 1'b0;
    cpol_i  = cpol;
    repeat (2) @(negedge clk_i);
    n_cmp++;
    if (sclk_o !== cpol) begin
      n_err++; $display("FAIL idle_sclk: got %b want %b", sclk_o, cpol);
    end
    n_cmp++;
    if ({cs_n_o, busy_o, done_o} !== 3'b100) begin
      n_err++; $display("FAIL idle_ctl: cs_n/busy/done got %b%b%b want 100", cs_n_o, busy_o, done_o);
    end
    tx_data_i   = tx;
    lsb_first_i = lsb;
    clk_div_i   = div;
    start_i     = 1'b1;
    @(posedge clk_i);
  endtask

  // Follows one accepted transfer cycle by cycle (cycle 1 = LOAD) up to DONE or stop_at.
  task automatic track_xfer(input logic [N-1:0] tx, input logic lsb, input logic cpol,
                            input logic [CW-1:0] div, input int miso_mode, input bit hold_start,
                            input logic [N-1:0] next_tx, input logic next_lsb, input int stop_at);
    int           d, p, done_c, last_c, off, k;
    bit           in_bits;
    logic         exp_en, exp_sclk;
    logic [N-1:0] exp_rx;
    logic [0:0]   exp_q[$];
    logic [0:0]   bit_v;
    d      = int'(div) + 1;
    p      = 2 * d + 1;
    done_c = 2 + N * p + d;
    last_c = (stop_at > 0 && stop_at < done_c) ? stop_at : done_c;
    for (int i = 0; i < N; i++) begin
      bit_v = lsb ? tx[i] : tx[N-1-i];
      exp_q.push_back(bit_v);
    end
    exp_rx    = (miso_mode == 0) ? tx : ((miso_mode == 1) ? '1 : '0);
    miso_loop = (miso_mode == 0);
    for (int c = 1; c <= last_c; c++) begin
      @(negedge clk_i);
      miso_drv = (miso_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      if (!hold_start) start_i = 1'b0;
      else if (c == done_c) begin
        tx_data_i   = next_tx;
        lsb_first_i = next_lsb;
      end else begin
        tx_data_i   = N'($urandom);
        lsb_first_i = 1'($urandom_range(0, 1));
      end
      in_bits  = (c >= 2) && (c < 2 + N * p);
      off      = in_bits ? (c - 2) % p : -1;
      k        = in_bits ? (c - 2) / p : N;
      exp_en   = in_bits && (off == 0);
      exp_sclk = (in_bits && off > d) ? ~cpol : cpol;

      n_cmp++;
      if (sh_ld_o !== (c == 1)) begin
        n_err++; $display("FAIL sh_ld c=%0d: got %b want %b", c, sh_ld_o, (c == 1));
      end
      n_cmp++;
      if (sh_en_o !== exp_en) begin
        n_err++; $display("FAIL sh_en c=%0d: got %b want %b", c, sh_en_o, exp_en);
      end
      n_cmp++;
      if (sclk_o !== exp_sclk) begin
        n_err++; $display("FAIL sclk c=%0d: got %b want %b", c, sclk_o, exp_sclk);
      end
      n_cmp++;
      if ({cs_n_o, busy_o, done_o} !== {(c == done_c), (c != done_c), (c == done_c)}) begin
        n_err++; $display("FAIL cs_busy_done c=%0d: got %b%b%b want %b%b%b", c, cs_n_o, busy_o,
                          done_o, (c == done_c), (c != done_c), (c == done_c));
      end
      n_cmp++;
      if (sh_rl_o !== lsb) begin
        n_err++; $display("FAIL sh_rl c=%0d: got %b want %b", c, sh_rl_o, lsb);
      end
      if (c == 1) begin
        n_cmp++;
        if (sh_data_o !== tx) begin
          n_err++; $display("FAIL sh_data: got %h want %h", sh_data_o, tx);
        end
      end
      if (in_bits && off >= 1 && off <= d) begin
        n_cmp++;
        if (exp_q.size() == 0 || mosi_o !== exp_q[0]) begin
          n_err++; $display("FAIL mosi c=%0d bit=%0d: got %b want %b", c, k, mosi_o,
                            (exp_q.size() == 0) ? 1'bx : exp_q[0]);
        end
        if (off == d) begin
          if (miso_mode == 2) exp_rx[lsb ? k : N-1-k] = miso_drv;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
      end
      n_cmp++;
      if (c == done_c) begin
        if (rx_data_o !== exp_rx) begin
          n_err++; $display("FAIL rx_data: got %h want %h", rx_data_o, exp_rx);
        end
        last_rx = exp_rx;
        n_cmp++;
        if (exp_q.size() != 0) begin
          n_err++; $display("FAIL mosi_count: %0d bits unseen, want 0", exp_q.size());
        end
      end else if (rx_data_o !== last_rx) begin
        n_err++; $display("FAIL rx_hold c=%0d: got %h want %h", c, rx_data_o, last_rx);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    n_cmp++;
    if (cs_n_o !== 1'b1) begin
      n_err++; $display("FAIL reset_cs_n: got %b want 1", cs_n_o);
    end
    n_cmp++;
    if ({busy_o, done_o, sh_ld_o, sh_en_o, sh_rl_o, sclk_o, mosi_o} !== 7'b0) begin
      n_err++; $display("FAIL reset_bits: got %b want 0000000",
                        {busy_o, done_o, sh_ld_o, sh_en_o, sh_rl_o, sclk_o, mosi_o});
    end
    n_cmp++;
    if ({rx_data_o, sh_data_o, state_o} !== '0) begin
      n_err++; $display("FAIL reset_words: rx %h sh_data %h state %0d want 0", rx_data_o,
                        sh_data_o, state_o);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_msb_loop();
    begin_xfer(8'hA5, 1'b0, 1'b0, 8'd0);
    track_xfer(8'hA5, 1'b0, 1'b0, 8'd0, 0, 1'b0, '0, 1'b0, 0);
  endtask

  task automatic test_lsb_ones();
    begin_xfer(8'h01, 1'b1, 1'b0, 8'd0);
    track_xfer(8'h01, 1'b1, 1'b0, 8'd0, 1, 1'b0, '0, 1'b0, 0);
  endtask

  task automatic test_cpol1();
    logic [N-1:0] tx;
    logic         lsb;
    tx  = N'($urandom);
    lsb = 1'($urandom_range(0, 1));
    begin_xfer(tx, lsb, 1'b1, 8'd3);
    track_xfer(tx, lsb, 1'b1, 8'd3, 2, 1'b0, '0, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] tx2;
    logic         lsb2;
    tx2  = N'($urandom);
    lsb2 = 1'($urandom_range(0, 1));
    begin_xfer(8'h3C, 1'b0, 1'b0, 8'd0);
    track_xfer(8'h3C, 1'b0, 1'b0, 8'd0, 0, 1'b1, tx2, lsb2, 0);
    track_xfer(tx2, lsb2, 1'b0, 8'd0, 0, 1'b0, '0, 1'b0, 0);
  endtask

  task automatic test_reset_mid();
    begin_xfer(N'($urandom), 1'b0, 1'b0, 8'd1);
    track_xfer(tx_data_i, 1'b0, 1'b0, 8'd1, 2, 1'b0, '0, 1'b0, 19);
    rst_i   = 1'b1;
    start_i = 1'b0;
    @(negedge clk_i);
    n_cmp++;
    if ({cs_n_o, busy_o, sclk_o, done_o, sh_en_o} !== 5'b10000) begin
      n_err++; $display("FAIL rst_mid_ctl: cs_n/busy/sclk/done/sh_en got %b%b%b%b%b want 10000",
                        cs_n_o, busy_o, sclk_o, done_o, sh_en_o);
    end
    n_cmp++;
    if (rx_data_o !== '0) begin
      n_err++; $display("FAIL rst_mid_rx: got %h want 00", rx_data_o);
    end
    rst_i   = 1'b0;
    last_rx = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      n_cmp++;
      if ({cs_n_o, done_o, sclk_o} !== 3'b100) begin
        n_err++; $display("FAIL rst_mid_idle: cs_n/done/sclk got %b%b%b want 100", cs_n_o,
                          done_o, sclk_o);
      end
    end
    begin_xfer(8'h5A, 1'b0, 1'b0, 8'd1);
    track_xfer(8'h5A, 1'b0, 1'b0, 8'd1, 0, 1'b0, '0, 1'b0, 0);
  endtask

  task automatic test_div_max();
    logic [N-1:0] tx;
    logic         lsb;
    tx  = N'($urandom);
    lsb = 1'($urandom_range(0, 1));
    begin_xfer(tx, lsb, 1'b0, 8'hFF);
    track_xfer(tx, lsb, 1'b0, 8'hFF, 2, 1'b0, '0, 1'b0, 0);
  endtask

  task automatic test_random();
    logic [N-1:0]  tx;
    logic          lsb, cpol;
    logic [CW-1:0] div;
    int            mode;
    for (int i = 0; i < 5; i++) begin
      tx   = N'($urandom);
      lsb  = 1'($urandom_range(0, 1));
      cpol = 1'($urandom_range(0, 1));
      div  = CW'($urandom_range(0, 4));
      mode = $urandom_range(0, 2);
      begin_xfer(tx, lsb, cpol, div);
      track_xfer(tx, lsb, cpol, div, mode, 1'b0, '0, 1'b0, 0);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp       = 0;
    n_err       = 0;
    last_rx     = '0;
    rst_i       = 1'b1;
    start_i     = 1'b0;
    tx_data_i   = '0;
    lsb_first_i = 1'b0;
    cpol_i      = 1'b0;
    clk_div_i   = '0;
    miso_loop   = 1'b0;
    miso_drv    = 1'b0;
    test_reset();
    test_msb_loop();
    test_lsb_ones();
    test_cpol1();
    test_back_to_back();
    test_reset_mid();
    test_div_max();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
